// File: rtl/cmd_encoder_pkg.sv
// Shared definitions for the host command encoder and the sequencer-side parser:
// op encodings, burst geometry, word field positions and the captured descriptor.
package cmd_encoder_pkg;

  localparam int unsigned CMD_BURST_LEN = 8;
  localparam int unsigned MAX_CMDS      = 127;
  localparam int unsigned CMD_IDX_W     = 3;
  localparam int unsigned CMD_SIZE_W    = 7;

  localparam logic [CMD_IDX_W-1:0]  LAST_WORD_IDX = CMD_IDX_W'(CMD_BURST_LEN - 1);
  localparam logic [CMD_SIZE_W-1:0] MAX_CMD_COUNT = CMD_SIZE_W'(MAX_CMDS);

  typedef enum logic [2:0] {
    OP_IDLE        = 3'd0,
    OP_CONV1X1     = 3'd1,
    OP_CONV3X3     = 3'd2,
    OP_CONV3X3_PAD = 3'd3,
    OP_MAXPOOL     = 3'd4,
    OP_AVEPOOL     = 3'd5
  } op_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_SEALED = 2'd2
  } enc_state_e;

  // Bit positions inside each command word, as parsed by the sequencer.
  localparam int unsigned W0_OP_LSB     = 0;
  localparam int unsigned W0_PAD_BIT    = 4;
  localparam int unsigned W0_STRIDE_LSB = 8;
  localparam int unsigned W0_CENTER_LSB = 16;
  localparam int unsigned W1_CORNER_LSB = 0;
  localparam int unsigned W1_SIDE_LSB   = 16;
  localparam int unsigned W2_ICH_LSB    = 0;
  localparam int unsigned W2_OCH_LSB    = 16;
  localparam int unsigned W3_ISIDE_LSB  = 0;
  localparam int unsigned W3_OSIDE_LSB  = 8;
  localparam int unsigned W3_KERNEL_LSB = 16;
  localparam int unsigned W4_ISURF_LSB  = 0;
  localparam int unsigned W4_OSURF_LSB  = 16;

  typedef struct packed {
    logic [2:0]  op_type;
    logic        padding;
    logic [3:0]  stride;
    logic [15:0] op_num_center;
    logic [15:0] op_num_corner;
    logic [15:0] op_num_side;
    logic [15:0] i_channel_size;
    logic [15:0] o_channel_size;
    logic [7:0]  i_side_size;
    logic [7:0]  o_side_size;
    logic [7:0]  kernel_size;
    logic [15:0] i_surf_size;
    logic [15:0] o_surf_size;
    logic [31:0] weight_start_addr;
    logic [31:0] data_start_addr;
    logic [31:0] result_start_addr;
  } cmd_desc_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    logic legal;
    case (op)
      OP_CONV1X1, OP_CONV3X3, OP_CONV3X3_PAD, OP_MAXPOOL, OP_AVEPOOL: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/cmd_word_pack.sv
// Combinational packer: selects and formats one of the eight command words
// from the captured descriptor.
import cmd_encoder_pkg::*;

module cmd_word_pack (
  input  cmd_desc_t            desc_i,
  input  logic [CMD_IDX_W-1:0] idx_i,
  output logic [31:0]          word_o
);

  always_comb begin
    word_o = 32'h0000_0000;
    case (idx_i)
      3'd0: begin
        word_o[W0_OP_LSB +: 3]      = desc_i.op_type;
        word_o[W0_PAD_BIT]          = desc_i.padding;
        word_o[W0_STRIDE_LSB +: 4]  = desc_i.stride;
        word_o[W0_CENTER_LSB +: 16] = desc_i.op_num_center;
      end
      3'd1: begin
        word_o[W1_CORNER_LSB +: 16] = desc_i.op_num_corner;
        word_o[W1_SIDE_LSB +: 16]   = desc_i.op_num_side;
      end
      3'd2: begin
        word_o[W2_ICH_LSB +: 16] = desc_i.i_channel_size;
        word_o[W2_OCH_LSB +: 16] = desc_i.o_channel_size;
      end
      3'd3: begin
        word_o[W3_ISIDE_LSB +: 8]  = desc_i.i_side_size;
        word_o[W3_OSIDE_LSB +: 8]  = desc_i.o_side_size;
        word_o[W3_KERNEL_LSB +: 8] = desc_i.kernel_size;
      end
      3'd4: begin
        word_o[W4_ISURF_LSB +: 16] = desc_i.i_surf_size;
        word_o[W4_OSURF_LSB +: 16] = desc_i.o_surf_size;
      end
      3'd5:    word_o = desc_i.weight_start_addr;
      3'd6:    word_o = desc_i.data_start_addr;
      3'd7:    word_o = desc_i.result_start_addr;
      default: word_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/cmd_encoder.sv
// Host command encoder: captures layer descriptors and writes each as an
// 8-word burst into the command FIFO, counting completed commands.
import cmd_encoder_pkg::*;

module cmd_encoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  op_type_i,
  input  logic        padding_i,
  input  logic [3:0]  stride_i,
  input  logic [15:0] op_num_center_i,
  input  logic [15:0] op_num_corner_i,
  input  logic [15:0] op_num_side_i,
  input  logic [15:0] i_channel_size_i,
  input  logic [15:0] o_channel_size_i,
  input  logic [7:0]  i_side_size_i,
  input  logic [7:0]  o_side_size_i,
  input  logic [7:0]  kernel_size_i,
  input  logic [15:0] i_surf_size_i,
  input  logic [15:0] o_surf_size_i,
  input  logic [31:0] weight_start_addr_i,
  input  logic [31:0] data_start_addr_i,
  input  logic [31:0] result_start_addr_i,
  input  logic        seal_i,
  input  logic        clear_i,
  input  logic        cmd_fifo_full_i,
  output logic        cmd_fifo_wr_en_o,
  output logic [31:0] cmd_fifo_din_o,
  output logic [6:0]  cmd_size_o,
  output logic        load_done_o,
  output logic        cmd_err_o
);

  enc_state_e            state_q, state_d;
  logic [CMD_IDX_W-1:0]  idx_q, idx_d;
  logic [CMD_SIZE_W-1:0] size_q, size_d;
  logic                  seal_pend_q, seal_pend_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  cmd_desc_t             desc_q, desc_d;

  cmd_desc_t   desc_in_s;
  logic        accept_s;
  logic        wr_en_s;
  logic [31:0] word_s;

  assign desc_in_s.op_type           = op_type_i;
  assign desc_in_s.padding           = padding_i;
  assign desc_in_s.stride            = stride_i;
  assign desc_in_s.op_num_center     = op_num_center_i;
  assign desc_in_s.op_num_corner     = op_num_corner_i;
  assign desc_in_s.op_num_side       = op_num_side_i;
  assign desc_in_s.i_channel_size    = i_channel_size_i;
  assign desc_in_s.o_channel_size    = o_channel_size_i;
  assign desc_in_s.i_side_size       = i_side_size_i;
  assign desc_in_s.o_side_size       = o_side_size_i;
  assign desc_in_s.kernel_size       = kernel_size_i;
  assign desc_in_s.i_surf_size       = i_surf_size_i;
  assign desc_in_s.o_surf_size       = o_surf_size_i;
  assign desc_in_s.weight_start_addr = weight_start_addr_i;
  assign desc_in_s.data_start_addr   = data_start_addr_i;
  assign desc_in_s.result_start_addr = result_start_addr_i;

  // Ready and write strobe are combinational so acceptance and FIFO writes act in the same cycle.
  assign cmd_ready_o = (state_q == ST_IDLE) & ~rst_i & (size_q != MAX_CMD_COUNT);
  assign accept_s    = cmd_valid_i & cmd_ready_o;
  assign wr_en_s     = (state_q == ST_BURST) & ~cmd_fifo_full_i;

  cmd_word_pack u_pack (
    .desc_i (desc_q),
    .idx_i  (idx_q),
    .word_o (word_s)
  );

  assign cmd_fifo_wr_en_o = wr_en_s;
  assign cmd_fifo_din_o   = (state_q == ST_BURST) ? word_s : 32'h0000_0000;
  assign cmd_size_o       = size_q;
  assign load_done_o      = done_q;
  assign cmd_err_o        = err_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    size_d      = size_q;
    seal_pend_d = seal_pend_q;
    desc_d      = desc_q;
    err_d       = 1'b0;
    done_d      = 1'b0;
    if (clear_i) begin
      state_d     = ST_IDLE;
      idx_d       = 3'd0;
      size_d      = 7'd0;
      seal_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            desc_d = desc_in_s;
            if (op_is_legal(op_type_i)) begin
              state_d     = ST_BURST;
              idx_d       = 3'd0;
              seal_pend_d = seal_i;
            end else begin
              // A dropped descriptor still honours a coincident seal.
              err_d = 1'b1;
              if (seal_i) begin
                state_d = ST_SEALED;
                done_d  = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end else if (seal_i) begin
            state_d = ST_SEALED;
            done_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BURST: begin
          seal_pend_d = seal_pend_q | seal_i;
          if (wr_en_s) begin
            if (idx_q == LAST_WORD_IDX) begin
              size_d      = size_q + 7'd1;
              idx_d       = 3'd0;
              seal_pend_d = 1'b0;
              if (seal_pend_q | seal_i) begin
                state_d = ST_SEALED;
                done_d  = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            idx_d = idx_q;
          end
        end
        ST_SEALED: state_d = ST_SEALED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // State, counters and shadow descriptor registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      size_q      <= 7'd0;
      seal_pend_q <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      desc_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      size_q      <= size_d;
      seal_pend_q <= seal_pend_d;
      err_q       <= err_d;
      done_q      <= done_d;
      desc_q      <= desc_d;
    end
  end

endmodule

// File: tb/tb_cmd_encoder.sv
// Self-checking bench for cmd_encoder: randomized descriptors and back-pressure
// checked against a field-level model of the eight-word command layout.
module tb_cmd_encoder;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, seal, clear, cmd_fifo_full;
  logic        cmd_fifo_wr_en, load_done, cmd_err;
  logic [31:0] cmd_fifo_din;
  logic [6:0]  cmd_size;
  logic [2:0]  op_type;
  logic        padding;
  logic [3:0]  stride;
  logic [15:0] op_num_center, op_num_corner, op_num_side, i_channel_size, o_channel_size;
  logic [7:0]  i_side_size, o_side_size, kernel_size;
  logic [15:0] i_surf_size, o_surf_size;
  logic [31:0] weight_start_addr, data_start_addr, result_start_addr;

  typedef struct {
    bit [2:0]  op;
    bit        pad;
    bit [3:0]  stride;
    bit [15:0] center, corner, side, ich, och;
    bit [7:0]  iside, oside, kern;
    bit [15:0] isurf, osurf;
    bit [31:0] waddr, daddr, raddr;
  } desc_t;

  int total = 0;
  int bad = 0;
  int exp_size = 0;
  logic [31:0] got_words [8];

  always #5 clk = ~clk;

  cmd_encoder dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .op_type_i(op_type), .padding_i(padding), .stride_i(stride),
    .op_num_center_i(op_num_center), .op_num_corner_i(op_num_corner), .op_num_side_i(op_num_side),
    .i_channel_size_i(i_channel_size), .o_channel_size_i(o_channel_size),
    .i_side_size_i(i_side_size), .o_side_size_i(o_side_size), .kernel_size_i(kernel_size),
    .i_surf_size_i(i_surf_size), .o_surf_size_i(o_surf_size),
    .weight_start_addr_i(weight_start_addr), .data_start_addr_i(data_start_addr),
    .result_start_addr_i(result_start_addr),
    .seal_i(seal), .clear_i(clear), .cmd_fifo_full_i(cmd_fifo_full),
    .cmd_fifo_wr_en_o(cmd_fifo_wr_en), .cmd_fifo_din_o(cmd_fifo_din),
    .cmd_size_o(cmd_size), .load_done_o(load_done), .cmd_err_o(cmd_err)
  );

  function automatic bit [31:0] exp_word(desc_t d, int i);
    case (i)
      0: return 32'(d.op) + (32'(d.pad) << 4) + (32'(d.stride) << 8) + (32'(d.center) << 16);
      1: return 32'(d.corner) + (32'(d.side) << 16);
      2: return 32'(d.ich) + (32'(d.och) << 16);
      3: return 32'(d.iside) + (32'(d.oside) << 8) + (32'(d.kern) << 16);
      4: return 32'(d.isurf) + (32'(d.osurf) << 16);
      5: return d.waddr;
      6: return d.daddr;
      7: return d.raddr;
      default: return 32'h0;
    endcase
  endfunction

  function automatic desc_t rand_desc(bit [2:0] op);
    desc_t d;
    d.op = op; d.pad = 1'($urandom); d.stride = 4'($urandom);
    d.center = 16'($urandom); d.corner = 16'($urandom); d.side = 16'($urandom);
    d.ich = 16'($urandom); d.och = 16'($urandom);
    d.iside = 8'($urandom); d.oside = 8'($urandom); d.kern = 8'($urandom);
    d.isurf = 16'($urandom); d.osurf = 16'($urandom);
    d.waddr = $urandom; d.daddr = $urandom; d.raddr = $urandom;
    return d;
  endfunction

  task automatic apply(input desc_t d);
    op_type = d.op; padding = d.pad; stride = d.stride;
    op_num_center = d.center; op_num_corner = d.corner; op_num_side = d.side;
    i_channel_size = d.ich; o_channel_size = d.och;
    i_side_size = d.iside; o_side_size = d.oside; kernel_size = d.kern;
    i_surf_size = d.isurf; o_surf_size = d.osurf;
    weight_start_addr = d.waddr; data_start_addr = d.daddr; result_start_addr = d.raddr;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_size = 0;
  endtask

  // Offers one descriptor and follows its burst; fmode 0 none, 1 random full, 2 full for 5 cycles at w3.
  task automatic run_cmd(input desc_t d, input int fmode, input int seal_word, output int cycles);
    int k; int fcnt; bit f; bit seal_sent;
    k = 0; fcnt = 0; seal_sent = 1'b0; cycles = 0; f = 1'b0;
    apply(d); cmd_valid = 1'b1; cmd_fifo_full = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL accept_ready got=%b exp=1", cmd_ready); bad++;
      @(posedge clk); #1; cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    apply(rand_desc(3'($urandom_range(0, 7))));
    while (k < 8 && cycles < 64) begin
      case (fmode)
        1: f = ($urandom_range(0, 2) == 0);
        2: begin f = (k == 3 && fcnt < 5); if (f) fcnt++; end
        default: f = 1'b0;
      endcase
      cmd_fifo_full = f;
      seal = (k == seal_word) && !seal_sent;
      if (seal) seal_sent = 1'b1;
      @(negedge clk);
      total++;
      if (cmd_fifo_wr_en !== !f) begin
        $display("FAIL burst_wr_en word=%0d got=%b exp=%b", k, cmd_fifo_wr_en, !f); bad++;
      end
      total++;
      if (cmd_fifo_din !== exp_word(d, k)) begin
        $display("FAIL burst_din word=%0d got=%h exp=%h", k, cmd_fifo_din, exp_word(d, k)); bad++;
      end
      total++;
      if (cmd_ready !== 1'b0) begin
        $display("FAIL busy_ready word=%0d got=%b exp=0", k, cmd_ready); bad++;
      end
      if (!f) begin got_words[k] = cmd_fifo_din; k++; end
      @(posedge clk); #1;
      cmd_fifo_full = 1'b0; seal = 1'b0; cycles++;
    end
    if (exp_size < 127) exp_size++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (cmd_ready !== 1'b0) begin $display("FAIL rst_ready got=%b exp=0", cmd_ready); bad++; end
    total++; if (cmd_fifo_wr_en !== 1'b0) begin $display("FAIL rst_wr_en got=%b exp=0", cmd_fifo_wr_en); bad++; end
    total++; if (cmd_fifo_din !== 32'h0) begin $display("FAIL rst_din got=%h exp=0", cmd_fifo_din); bad++; end
    total++; if (cmd_size !== 7'd0) begin $display("FAIL rst_size got=%0d exp=0", cmd_size); bad++; end
    total++; if (load_done !== 1'b0) begin $display("FAIL rst_load_done got=%b exp=0", load_done); bad++; end
    total++; if (cmd_err !== 1'b0) begin $display("FAIL rst_err got=%b exp=0", cmd_err); bad++; end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_size = 0;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin $display("FAIL post_rst_ready got=%b exp=1", cmd_ready); bad++; end
    @(posedge clk); #1;
  endtask

  task automatic test_single_conv();
    desc_t d; int cyc;
    d = rand_desc(3'd2);
    d.stride = 4'd1; d.pad = 1'b0; d.center = 16'h00C4; d.waddr = 32'h0000_1000;
    run_cmd(d, 0, -1, cyc);
    total++; if (cyc != 8) begin $display("FAIL single_cycles got=%0d exp=8", cyc); bad++; end
    total++; if (got_words[0] !== 32'h00C4_0102) begin $display("FAIL single_w0 got=%h exp=00c40102", got_words[0]); bad++; end
    total++; if (got_words[5] !== 32'h0000_1000) begin $display("FAIL single_w5 got=%h exp=00001000", got_words[5]); bad++; end
    @(negedge clk);
    total++; if (cmd_size !== 7'(exp_size)) begin $display("FAIL single_size got=%0d exp=%0d", cmd_size, exp_size); bad++; end
    total++; if (cmd_ready !== 1'b1) begin $display("FAIL single_ready_after got=%b exp=1", cmd_ready); bad++; end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int cyc;
    run_cmd(rand_desc(3'($urandom_range(1, 5))), 2, -1, cyc);
    total++; if (cyc != 13) begin $display("FAIL bp_cycles got=%0d exp=13", cyc); bad++; end
    @(negedge clk);
    total++; if (cmd_size !== 7'(exp_size)) begin $display("FAIL bp_size got=%0d exp=%0d", cmd_size, exp_size); bad++; end
    @(posedge clk); #1;
  endtask

  task automatic test_random_stream();
    int cyc;
    for (int i = 0; i < 6; i++) begin
      run_cmd(rand_desc(3'($urandom_range(1, 5))), 1, -1, cyc);
      @(negedge clk);
      total++; if (cmd_size !== 7'(exp_size)) begin $display("FAIL rand_size cmd=%0d got=%0d exp=%0d", i, cmd_size, exp_size); bad++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_op();
    bit [2:0] ops [3];
    ops[0] = 3'd6; ops[1] = 3'd0; ops[2] = 3'd7;
    for (int i = 0; i < 3; i++) begin
      apply(rand_desc(ops[i])); cmd_valid = 1'b1;
      @(negedge clk);
      total++; if (cmd_ready !== 1'b1) begin $display("FAIL ill_ready op=%0d got=%b exp=1", ops[i], cmd_ready); bad++; end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      total++; if (cmd_err !== 1'b1) begin $display("FAIL ill_err op=%0d got=%b exp=1", ops[i], cmd_err); bad++; end
      total++; if (cmd_fifo_wr_en !== 1'b0) begin $display("FAIL ill_wr_en op=%0d got=%b exp=0", ops[i], cmd_fifo_wr_en); bad++; end
      total++; if (cmd_ready !== 1'b1) begin $display("FAIL ill_ready_next op=%0d got=%b exp=1", ops[i], cmd_ready); bad++; end
      total++; if (cmd_size !== 7'(exp_size)) begin $display("FAIL ill_size op=%0d got=%0d exp=%0d", ops[i], cmd_size, exp_size); bad++; end
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (cmd_err !== 1'b0) begin $display("FAIL ill_err_pulse op=%0d got=%b exp=0", ops[i], cmd_err); bad++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_seal_mid_burst();
    int cyc;
    do_clear();
    run_cmd(rand_desc(3'($urandom_range(1, 5))), 0, -1, cyc);
    run_cmd(rand_desc(3'($urandom_range(1, 5))), 1, -1, cyc);
    run_cmd(rand_desc(3'($urandom_range(1, 5))), 0, 4, cyc);
    @(negedge clk);
    total++; if (load_done !== 1'b1) begin $display("FAIL seal_load_done got=%b exp=1", load_done); bad++; end
    total++; if (cmd_size !== 7'd3) begin $display("FAIL seal_size got=%0d exp=3", cmd_size); bad++; end
    @(posedge clk); #1;
    apply(rand_desc(3'($urandom_range(1, 5)))); cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (cmd_ready !== 1'b0) begin $display("FAIL sealed_ready cyc=%0d got=%b exp=0", i, cmd_ready); bad++; end
      total++; if (cmd_fifo_wr_en !== 1'b0) begin $display("FAIL sealed_wr_en cyc=%0d got=%b exp=0", i, cmd_fifo_wr_en); bad++; end
      total++; if (load_done !== 1'b0) begin $display("FAIL sealed_done_pulse cyc=%0d got=%b exp=0", i, load_done); bad++; end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_clear_mid_burst();
    desc_t d; int cyc;
    do_clear();
    run_cmd(rand_desc(3'($urandom_range(1, 5))), 0, -1, cyc);
    d = rand_desc(3'($urandom_range(1, 5)));
    apply(d); cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) clear = 1'b1;
      @(negedge clk);
      total++; if (cmd_fifo_din !== exp_word(d, k)) begin $display("FAIL clr_pre_din word=%0d got=%h exp=%h", k, cmd_fifo_din, exp_word(d, k)); bad++; end
      @(posedge clk); #1;
    end
    clear = 1'b0;
    exp_size = 0;
    @(negedge clk);
    total++; if (cmd_size !== 7'd0) begin $display("FAIL clr_size got=%0d exp=0", cmd_size); bad++; end
    total++; if (cmd_ready !== 1'b1) begin $display("FAIL clr_ready got=%b exp=1", cmd_ready); bad++; end
    for (int i = 0; i < 4; i++) begin
      total++; if (cmd_fifo_wr_en !== 1'b0) begin $display("FAIL clr_wr_en cyc=%0d got=%b exp=0", i, cmd_fifo_wr_en); bad++; end
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_max_cmds();
    int cyc;
    do_clear();
    for (int i = 0; i < 127; i++) run_cmd(rand_desc(3'($urandom_range(1, 5))), 0, -1, cyc);
    @(negedge clk);
    total++; if (cmd_size !== 7'd127) begin $display("FAIL max_size got=%0d exp=127", cmd_size); bad++; end
    total++; if (cmd_ready !== 1'b0) begin $display("FAIL max_ready got=%b exp=0", cmd_ready); bad++; end
    @(posedge clk); #1;
    apply(rand_desc(3'($urandom_range(1, 5)))); cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (cmd_ready !== 1'b0) begin $display("FAIL max_extra_ready cyc=%0d got=%b exp=0", i, cmd_ready); bad++; end
      total++; if (cmd_fifo_wr_en !== 1'b0) begin $display("FAIL max_extra_wr_en cyc=%0d got=%b exp=0", i, cmd_fifo_wr_en); bad++; end
      total++; if (cmd_size !== 7'd127) begin $display("FAIL max_extra_size cyc=%0d got=%0d exp=127", i, cmd_size); bad++; end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    do_clear();
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin $display("FAIL max_clear_ready got=%b exp=1", cmd_ready); bad++; end
    total++; if (cmd_size !== 7'd0) begin $display("FAIL max_clear_size got=%0d exp=0", cmd_size); bad++; end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; seal = 1'b0; clear = 1'b0; cmd_fifo_full = 1'b0;
    apply(rand_desc(3'd0));
    test_reset();
    test_single_conv();
    test_backpressure();
    test_random_stream();
    test_illegal_op();
    test_seal_mid_burst();
    test_clear_mid_burst();
    test_max_cmds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_encoder.md
# cmd_encoder

Host-side command encoder that serializes layer descriptors into the 32-bit command FIFO feeding the command-sequencing block. Each accepted descriptor is packed into 8 words (CMD_BURST_LEN) in the exact order and bit layout the sequencer parses, written under FIFO back-pressure. The block keeps a running command count, which drives the sequencer's `cmd_size` input after the list is sealed.

## Interface
- `CMD_BURST_LEN`, 8: words per command; layout below is defined only for 8.
- `MAX_CMDS`, 127: maximum commands per list; equals the 7-bit `cmd_size` ceiling.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  descriptor fields valid.
- `cmd_ready`  out  1  descriptor accepted when `cmd_valid & cmd_ready`.
- Descriptor fields, all inputs:
  - `op_type` 3, `padding` 1, `stride` 4.
  - `op_num_center`, `op_num_corner`, `op_num_side` 16 each.
  - `i_channel_size`, `o_channel_size` 16 each.
  - `i_side_size`, `o_side_size`, `kernel_size` 8 each.
  - `i_surf_size`, `o_surf_size` 16 each.
  - `weight_start_addr`, `data_start_addr`, `result_start_addr` 32 each.
- `seal`  in  1  pulse: end of command list.
- `clear`  in  1  pulse: discard list, restart.
- `cmd_fifo_full`  in  1  FIFO cannot accept a write this cycle.
- `cmd_fifo_wr_en`  out  1  FIFO write strobe.
- `cmd_fifo_din`  out  32  FIFO write data.
- `cmd_size`  out  7  commands fully written.
- `load_done`  out  1  one-cycle pulse when the list is sealed.
- `cmd_err`  out  1  one-cycle pulse on a rejected descriptor.

## Operation
- States:
  - **IDLE**: accepts descriptors.
  - **BURST**: writes words 0..7 of the captured descriptor.
  - **SEALED**: list closed; no acceptance.
- Word layout. All unlisted bits are 0.
  - w0: [2:0] op_type, [4] padding, [11:8] stride, [31:16] op_num_center.
  - w1: [15:0] op_num_corner, [31:16] op_num_side.
  - w2: [15:0] i_channel_size, [31:16] o_channel_size.
  - w3: [7:0] i_side_size, [15:8] o_side_size, [23:16] kernel_size.
  - w4: [15:0] i_surf_size, [31:16] o_surf_size.
  - w5: weight_start_addr. w6: data_start_addr. w7: result_start_addr.
- `cmd_ready` = IDLE & ~rst & (`cmd_size` != MAX_CMDS). Combinational; no registered-ready double-accept hazard.
- On accept, all fields are captured into shadow registers; the inputs may then change freely.
- op_type legality:
  - 1..5: go to BURST with word index 0.
  - 0, 6, 7: descriptor dropped, no FIFO write, `cmd_err` pulses the next cycle, stay in IDLE.
- BURST writes:
  - `cmd_fifo_wr_en` = BURST & ~`cmd_fifo_full` (combinational).
  - `cmd_fifo_din` = w[index].
  - Index advances only on a write.
  - After the w7 write: `cmd_size` +1, return to IDLE.
- `seal`:
  - In IDLE: go to SEALED; `load_done` pulses the next cycle.
  - In BURST: latched; applied on return to IDLE, with `load_done` one cycle after the w7 write.
  - In SEALED: ignored.
- `cmd_valid` and `seal` in the same IDLE cycle: the descriptor is accepted; the seal is latched and applied after its burst.
- `clear` (highest priority after `rst`):
  - Next state IDLE; `cmd_size`, index and latched seal cleared.
  - A partial burst is abandoned; the FIFO owner must flush the FIFO alongside.
- `cmd_size` never wraps. At MAX_CMDS, `cmd_ready` stays 0 until `clear` or `rst`.

## Timing
- Reset values: `cmd_ready` 0, `cmd_fifo_wr_en` 0, `cmd_fifo_din` 0, `cmd_size` 0, `load_done` 0, `cmd_err` 0; state IDLE.
- Accept at cycle N; the earliest w0 write is at N+1. With no back-pressure, w7 is written at N+8, `cmd_size` updates at N+9, and the next accept can happen at N+9.
- Each full cycle extends the burst by one cycle; data stays on w[index] until written.
- `rst` or `clear` mid-burst: `cmd_fifo_wr_en` is 0 from the next cycle.

## Structure
- Shared package holds:
  - op_type encodings: IDLE 0, CONV1x1 1, CONV3x3 2, CONV3x3_PAD 3, MAXPOOL 4, AVEPOOL 5.
  - CMD_BURST_LEN.
  - Word field bit positions, shared with the sequencer parser.
- Sub-module `cmd_word_pack`: combinational, shadow fields + 3-bit index -> 32-bit word.

## Test plan
- **Single conv command, no back-pressure.**
  - Stimulus: op_type 2, stride 1, op_num_center 0x00C4, weight_start_addr 0x0000_1000.
  - Required: 8 consecutive writes; w0 = 0x00C4_0102; w5 = 0x0000_1000; `cmd_size` 1 at N+9.
- **FIFO full held during w3 for 5 cycles.**
  - Required: w3 is held stable on `cmd_fifo_din` with `cmd_fifo_wr_en` 0 for those 5 cycles; the burst completes 5 cycles late.
  - Required: exactly 8 writes, with no duplicate or skipped word.
- **op_type 6 descriptor.**
  - Required: no write; `cmd_err` pulse at N+1; `cmd_size` unchanged; `cmd_ready` 1 at N+1.
- **`seal` asserted at w4 of the 3rd command.**
  - Required: `load_done` pulses one cycle after w7; `cmd_size` 3; `cmd_ready` then stays 0.
- **127 back-to-back commands.**
  - Required: `cmd_ready` 0 once `cmd_size` reaches 127; a 128th `cmd_valid` is ignored.
- **`clear` at w2 of a burst.**
  - Required: no writes from the next cycle on; `cmd_size` 0; `cmd_ready` 1 the next cycle.
